arcade_input_conditioner: RTL

- Sits between the keyboard/joystick mapping stage and the arcade core's active-low button inputs.
- Synchronises and debounces every player control.
- Shapes each coin input into exactly one fixed-width, active-low pulse per insertion, with a re-arm gap, so the core's CPU always samples a credit once regardless of how long the key is held.

---
 rtl/arcade_input_conditioner.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/arcade_input_conditioner.sv
// Input conditioner between the key/joystick mapper and an arcade core's active-low buttons:
// synchronises and debounces every control, and shapes each coin key into one fixed-length credit pulse.
//
// Coin channel states:
//   state      | meaning
//   C_IDLE     | armed, waiting for a debounced coin press
//   C_PULSE    | coin_n_o held low for COIN_TICKS ticks
//   C_WAIT_REL | pulse done, waiting for the debounced coin release
//   C_GAP      | re-arm gap of COIN_GAP ticks, presses ignored
module arcade_input_conditioner #(
    parameter int TICK_DIV   = 20000,
    parameter int NBUT       = 16,
    parameter int DEB_TICKS  = 4,
    parameter int COIN_TICKS = 50,
    parameter int COIN_GAP   = 50
) (
    input  logic            clk_sys,
    input  logic            res_n_i,
    input  logic [NBUT-1:0] btn_i,
    input  logic [1:0]      coin_i,
    output logic [NBUT-1:0] btn_n_o,
    output logic [1:0]      coin_n_o,
    output logic [1:0]      coin_busy_o,
    output logic            tick_o
);

    localparam int NCH  = NBUT + 2;
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW   = $clog2(DEB_TICKS + 1);
    localparam int CMAX = (COIN_TICKS > COIN_GAP) ? COIN_TICKS : COIN_GAP;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(COIN_TICKS - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(COIN_GAP - 1);

    typedef enum logic [1:0] {
        C_IDLE     = 2'd0,
        C_PULSE    = 2'd1,
        C_WAIT_REL = 2'd2,
        C_GAP      = 2'd3
    } coin_state_t;

    // Reset asserts immediately but releases two clk_sys edges later, in step with the clock.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk_sys or negedge res_n_i) begin
        if (!res_n_i) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    logic [PW-1:0] pre_cnt;
    logic          tick;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    assign tick   = (pre_cnt == PRE_LAST);
    assign tick_o = tick;

    logic [NCH-1:0] raw;
    logic [NCH-1:0] sync_a;
    logic [NCH-1:0] sync_b;

    assign raw = {coin_i, btn_i};

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    logic [NCH-1:0] stable;

    for (genvar g = 0; g < NCH; g++) begin : g_deb
        logic          stb;
        logic [DW-1:0] cnt;

        always_ff @(posedge clk_sys or negedge rst_n) begin
            if (!rst_n) begin
                stb <= 1'b0;
                cnt <= '0;
            end else if (tick) begin
                if (sync_b[g] == stb) begin
                    cnt <= '0;
                end else if (cnt == DEB_LAST) begin
                    stb <= ~stb;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + DW'(1);
                end
            end
        end

        assign stable[g] = stb;
    end

    assign btn_n_o = ~stable[NBUT-1:0];

    for (genvar c = 0; c < 2; c++) begin : g_coin
        coin_state_t   state;
        coin_state_t   state_nx;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nx;
        logic          cdb;

        assign cdb = stable[NBUT+c];

        always_ff @(posedge clk_sys or negedge rst_n) begin
            if (!rst_n) begin
                state <= C_IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
            end
        end

        // A release during the pulse is seen in WAIT_REL and leaves on the next cycle.
        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            case (state)
                C_IDLE: begin
                    if (cdb) begin
                        state_nx = C_PULSE;
                        cnt_nx   = '0;
                    end
                end
                C_PULSE: begin
                    if (tick) begin
                        if (cnt == PULSE_LAST) begin
                            state_nx = C_WAIT_REL;
                        end else begin
                            cnt_nx = cnt + CW'(1);
                        end
                    end
                end
                C_WAIT_REL: begin
                    if (!cdb) begin
                        state_nx = C_GAP;
                        cnt_nx   = '0;
                    end
                end
                C_GAP: begin
                    if (tick) begin
                        if (cnt == GAP_LAST) begin
                            state_nx = C_IDLE;
                        end else begin
                            cnt_nx = cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state_nx = C_IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end

        // Decoded straight from the state flop so an asynchronous reset lifts the pulse at once.
        assign coin_n_o[c]    = (state != C_PULSE);
        assign coin_busy_o[c] = (state != C_IDLE);
    end

endmodule
